collision_scan_scheduler: RTL and testbench
===========================================

Name: collision_scan_scheduler

Overview:
Frame-level sequencer for the game's collision datapath. On each frame tick it snapshots the player, sword and dragon-segment positions. It then time-shares one 8-bit equality comparator across all segments in two passes: player vs segments, then sword vs segments. Results are published atomically with a one-cycle done pulse, for consumption by the game-state and render logic.

Parameters:
NUM_SEGMENTS, 7, number of dragon segments scanned (1..15)
POS_W, 8, position width in bits ({x[3:0], y[3:0]} packed)
IDX_W, 4, segment index / counter width; must satisfy 2^IDX_W > NUM_SEGMENTS

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
frame_tick  input  1  one-cycle pulse starting a scan
player_pos  input  POS_W  player position
sword_pos  input  POS_W  sword position
sword_active  input  1  sword currently deployed
segment_positions  input  NUM_SEGMENTS*POS_W  segment i at bits [i*POS_W +: POS_W]
segment_valid  input  NUM_SEGMENTS  per-segment enable (dragon length mask)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when results are published
player_hit  output  1  player overlaps any valid segment (held until next done)
sword_hit  output  1  OR of sword_hit_mask (held)
sword_hit_mask  output  NUM_SEGMENTS  bit i set = sword overlaps valid segment i (held)
tick_overrun  output  1  one-cycle pulse: frame_tick arrived while busy

Behaviour:
- Reset (reset==0 at posedge clk): state=IDLE, idx=0. All outputs and working accumulators are 0. Reset wins over every other event, including mid-scan; no done is issued for an aborted scan.
- States: IDLE, SCAN_PLAYER, SCAN_SWORD, PUBLISH.
- IDLE: on frame_tick, at the same edge (edge 0), register snapshots of every position input, segment_valid and sword_active. Clear the accumulators, set idx=0, go to SCAN_PLAYER.
- SCAN_PLAYER: each cycle, compare snap_player vs snap_seg[idx] and AND the result with snap_valid[idx]. The result ORs into acc_player at the next edge; idx increments. After idx==NUM_SEGMENTS-1 is processed: idx=0, go to SCAN_SWORD. This takes edges 1..N.
- SCAN_SWORD: same single shared comparator, operand snap_sword. The result, ANDed with snap_valid[idx] and snap_sword_active, is written to acc_mask[idx]. Takes edges N+1..2N, then goes to PUBLISH.
- PUBLISH (edge 2N+1): copy the accumulators to player_hit, sword_hit_mask and sword_hit. done=1 for exactly one cycle. Go to IDLE.
- Fixed latency: done is asserted 2N+1 edges after tick sampling (15 for N=7), regardless of mask or sword state. Invalid segments still consume their cycle.
- Exactly one comparator instance; no parallel compares.
- frame_tick while state != IDLE (this includes PUBLISH): ignored, tick_overrun=1 for one cycle, and the scan continues unaltered.
- Inputs that change after edge 0 have no effect on the current scan.
- Outputs keep their previous results while busy, and update only at PUBLISH.

Optional Feature:
COLLISION_HIT_INDEX_EN
- Defined: adds output hit_index [IDX_W-1:0]. It holds the lowest segment index matched by the player in the last scan, and is updated at PUBLISH. It reads as all-ones when player_hit=0, and resets to all-ones. The first match is captured during SCAN_PLAYER, and later matches do not overwrite it.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset low for 3 cycles, no tick -> busy=0, done=0, player_hit=0, sword_hit_mask=0x00, tick_overrun=0.
2. N=7, segment_valid=0x7F, player_pos=0x34, seg2=0x34, others distinct, sword_active=0, tick -> done pulses exactly 15 cycles after tick edge; player_hit=1, sword_hit=0, mask=0x00; hit_index=2 if enabled.
3. Same as 2 but seg5=0x34 instead of seg2, with segment_valid=0x1F -> player_hit=0; hit_index=0xF if enabled.
4. sword_pos=0x12, seg1=seg4=0x12, sword_active=1, valid=0x7F -> sword_hit_mask=0x12, sword_hit=1. Repeat with sword_active=0 -> mask=0x00.
5. Tick with player_pos=0x34 matching seg3, then change player_pos to 0x00 at edge 3 -> result still player_hit=1. A second tick at edge 5 -> tick_overrun pulses once, and done fires only once at edge 15.
6. Tick, then reset low at edge 6 for 1 cycle -> busy=0 next edge, outputs 0, no done. A new tick afterwards completes normally in 15 cycles.

Source files
------------

// File: rtl/collision_scan_scheduler.sv
// Frame-level collision sequencer: snapshots positions on frame_tick and time-shares one comparator.
// Optional macro COLLISION_HIT_INDEX_EN adds hit_index (lowest player-matched segment).
module collision_scan_scheduler #(
  parameter int NUM_SEGMENTS = 7,
  parameter int POS_W        = 8,
  parameter int IDX_W        = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic [POS_W-1:0]              player_pos,
  input  logic [POS_W-1:0]              sword_pos,
  input  logic                          sword_active,
  input  logic [NUM_SEGMENTS*POS_W-1:0] segment_positions,
  input  logic [NUM_SEGMENTS-1:0]       segment_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          player_hit,
  output logic                          sword_hit,
  output logic [NUM_SEGMENTS-1:0]       sword_hit_mask,
`ifdef COLLISION_HIT_INDEX_EN
  output logic [IDX_W-1:0]              hit_index,
`endif
  output logic                          tick_overrun
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_SCAN_PLAYER = 2'd1,
    S_SCAN_SWORD  = 2'd2,
    S_PUBLISH     = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                          w_start;
  logic                          w_scan_p;
  logic                          w_scan_s;
  logic                          w_publish;
  logic                          w_last;

  logic [POS_W-1:0]              r_snap_player;
  logic [POS_W-1:0]              r_snap_sword;
  logic                          r_snap_sword_active;
  logic [NUM_SEGMENTS*POS_W-1:0] r_snap_seg;
  logic [NUM_SEGMENTS-1:0]       r_snap_valid;
  logic [IDX_W-1:0]              r_idx;

  logic                          r_acc_player;
  logic [NUM_SEGMENTS-1:0]       r_acc_mask;
  logic [IDX_W-1:0]              r_acc_first;

  logic                          r_done;
  logic                          r_player_hit;
  logic                          r_sword_hit;
  logic [NUM_SEGMENTS-1:0]       r_sword_hit_mask;
  logic                          r_tick_overrun;
  logic [IDX_W-1:0]              r_hit_index;

  logic [POS_W-1:0]              w_seg_sel;
  logic                          w_valid_sel;
  logic [POS_W-1:0]              w_cmp_a;
  logic                          w_eq;
  logic                          w_hit_player;
  logic                          w_hit_sword;
  logic [NUM_SEGMENTS-1:0]       w_mask_next;

  assign w_last = (r_idx == IDX_W'(NUM_SEGMENTS - 1));

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_scan_p     = 1'b0;
    w_scan_s     = 1'b0;
    w_publish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_tick) begin
          w_start      = 1'b1;
          w_state_next = S_SCAN_PLAYER;
        end
      end
      S_SCAN_PLAYER: begin
        w_scan_p = 1'b1;
        if (w_last) w_state_next = S_SCAN_SWORD;
      end
      S_SCAN_SWORD: begin
        w_scan_s = 1'b1;
        if (w_last) w_state_next = S_PUBLISH;
      end
      S_PUBLISH: begin
        w_publish    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Segment select by explicit decode so the index width need not match the array depth
  always_comb begin
    w_seg_sel   = '0;
    w_valid_sel = 1'b0;
    for (int i = 0; i < NUM_SEGMENTS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_seg_sel   = r_snap_seg[i*POS_W +: POS_W];
        w_valid_sel = r_snap_valid[i];
      end
    end
  end

  // The one shared equality comparator; operand A switches with the pass
  assign w_cmp_a      = (r_state == S_SCAN_SWORD) ? r_snap_sword : r_snap_player;
  assign w_eq         = (w_cmp_a == w_seg_sel);
  assign w_hit_player = w_eq & w_valid_sel;
  assign w_hit_sword  = w_eq & w_valid_sel & r_snap_sword_active;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEGMENTS; gi++) begin : g_mask
      assign w_mask_next[gi] = (w_scan_s && (r_idx == IDX_W'(gi))) ? w_hit_sword : r_acc_mask[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_snap_player       <= '0;
      r_snap_sword        <= '0;
      r_snap_sword_active <= 1'b0;
      r_snap_seg          <= '0;
      r_snap_valid        <= '0;
      r_idx               <= '0;
      r_acc_player        <= 1'b0;
      r_acc_mask          <= '0;
      r_acc_first         <= '1;
      r_done              <= 1'b0;
      r_player_hit        <= 1'b0;
      r_sword_hit         <= 1'b0;
      r_sword_hit_mask    <= '0;
      r_tick_overrun      <= 1'b0;
      r_hit_index         <= '1;
    end else begin
      r_done         <= w_publish;
      r_tick_overrun <= frame_tick && (r_state != S_IDLE);
      if (w_start) begin
        r_snap_player       <= player_pos;
        r_snap_sword        <= sword_pos;
        r_snap_sword_active <= sword_active;
        r_snap_seg          <= segment_positions;
        r_snap_valid        <= segment_valid;
        r_idx               <= '0;
        r_acc_player        <= 1'b0;
        r_acc_mask          <= '0;
        r_acc_first         <= '1;
      end
      if (w_scan_p) begin
        if (w_hit_player) r_acc_player <= 1'b1;
        // Only the first match of the pass is kept
        if (w_hit_player && !r_acc_player) r_acc_first <= r_idx;
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      end
      if (w_scan_s) begin
        r_acc_mask <= w_mask_next;
        r_idx      <= w_last ? '0 : r_idx + IDX_W'(1);
      end
      if (w_publish) begin
        r_player_hit     <= r_acc_player;
        r_sword_hit_mask <= r_acc_mask;
        r_sword_hit      <= |r_acc_mask;
        r_hit_index      <= r_acc_first;
      end
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign player_hit     = r_player_hit;
  assign sword_hit      = r_sword_hit;
  assign sword_hit_mask = r_sword_hit_mask;
  assign tick_overrun   = r_tick_overrun;
`ifdef COLLISION_HIT_INDEX_EN
  assign hit_index      = r_hit_index;
`else
  logic w_unused_hit_index;
  assign w_unused_hit_index = ^r_hit_index;
`endif

endmodule

// File: tb/tb_collision_scan_scheduler.sv
// Directed bench for collision_scan_scheduler; inputs driven and outputs sampled on the falling edge.
module tb_collision_scan_scheduler;

  localparam int N     = 7;
  localparam int POS_W = 8;
  localparam int IDX_W = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  frame_tick = 1'b0;
  logic [POS_W-1:0]      player_pos = '0;
  logic [POS_W-1:0]      sword_pos = '0;
  logic                  sword_active = 1'b0;
  logic [N*POS_W-1:0]    segment_positions = '0;
  logic [N-1:0]          segment_valid = '0;
  logic                  busy;
  logic                  done;
  logic                  player_hit;
  logic                  sword_hit;
  logic [N-1:0]          sword_hit_mask;
  logic                  tick_overrun;
`ifdef COLLISION_HIT_INDEX_EN
  logic [IDX_W-1:0]      hit_index;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  collision_scan_scheduler #(.NUM_SEGMENTS(N), .POS_W(POS_W), .IDX_W(IDX_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .frame_tick        (frame_tick),
    .player_pos        (player_pos),
    .sword_pos         (sword_pos),
    .sword_active      (sword_active),
    .segment_positions (segment_positions),
    .segment_valid     (segment_valid),
    .busy              (busy),
    .done              (done),
    .player_hit        (player_hit),
    .sword_hit         (sword_hit),
    .sword_hit_mask    (sword_hit_mask),
`ifdef COLLISION_HIT_INDEX_EN
    .hit_index         (hit_index),
`endif
    .tick_overrun      (tick_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse frame_tick over one rising edge (edge 0), then wait up to 40 edges for done
  task automatic run_scan(input string tag);
    int lat;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd15);
    $display("scan %s latency=%0d player_hit=%0b sword_hit=%0b mask=%02h", tag, lat, player_hit, sword_hit, sword_hit_mask);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int done_cnt;
    int done_edge;
    int ovr_cnt;

    // 1: reset held low for 3 cycles
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_player_hit", 32'(player_hit), 32'd0);
    check("rst_mask", 32'(sword_hit_mask), 32'h00);
    check("rst_overrun", 32'(tick_overrun), 32'd0);
`ifdef COLLISION_HIT_INDEX_EN
    check("rst_hit_index", 32'(hit_index), 32'hF);
`endif
    reset = 1'b1;
    @(negedge clk);
    $display("reset released");

    // 2: player matches seg2
    player_pos        = 8'h34;
    sword_pos         = 8'h12;
    sword_active      = 1'b0;
    segment_valid     = 7'h7F;
    segment_positions = {8'h07, 8'h06, 8'h05, 8'h04, 8'h34, 8'h02, 8'h01};
    run_scan("t2");
    check("t2_player_hit", 32'(player_hit), 32'd1);
    check("t2_sword_hit", 32'(sword_hit), 32'd0);
    check("t2_mask", 32'(sword_hit_mask), 32'h00);
`ifdef COLLISION_HIT_INDEX_EN
    check("t2_hit_index", 32'(hit_index), 32'd2);
`endif

    // 3: match only on seg5, which is masked out; previous result held while busy
    segment_valid     = 7'h1F;
    segment_positions = {8'h07, 8'h34, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    check("t3_held_player_hit", 32'(player_hit), 32'd1);
    done_edge = -1;
    for (int e = 6; e <= 40; e++) begin
      @(negedge clk);
      if (done) begin
        done_edge = e;
        break;
      end
    end
    check("t3_latency", 32'(done_edge), 32'd15);
    check("t3_player_hit", 32'(player_hit), 32'd0);
`ifdef COLLISION_HIT_INDEX_EN
    check("t3_hit_index", 32'(hit_index), 32'hF);
`endif
    $display("scan t3 latency=%0d player_hit=%0b", done_edge, player_hit);
    @(negedge clk);

    // 4: sword overlaps seg1 and seg4
    player_pos        = 8'h34;
    sword_pos         = 8'h12;
    sword_active      = 1'b1;
    segment_valid     = 7'h7F;
    segment_positions = {8'h07, 8'h06, 8'h12, 8'h04, 8'h03, 8'h12, 8'h01};
    run_scan("t4a");
    check("t4a_mask", 32'(sword_hit_mask), 32'h12);
    check("t4a_sword_hit", 32'(sword_hit), 32'd1);
    check("t4a_player_hit", 32'(player_hit), 32'd0);
    sword_active = 1'b0;
    run_scan("t4b");
    check("t4b_mask", 32'(sword_hit_mask), 32'h00);
    check("t4b_sword_hit", 32'(sword_hit), 32'd0);
    sword_active  = 1'b1;
    segment_valid = 7'h0F;
    run_scan("t4c");
    check("t4c_mask", 32'(sword_hit_mask), 32'h02);

    // 5: input change mid-scan and an overrun tick
    player_pos        = 8'h34;
    sword_active      = 1'b0;
    segment_valid     = 7'h7F;
    segment_positions = {8'h07, 8'h06, 8'h05, 8'h34, 8'h03, 8'h02, 8'h01};
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    done_cnt  = 0;
    done_edge = -1;
    ovr_cnt   = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_edge = e;
      end
      if (tick_overrun) ovr_cnt++;
      if (e == 2) player_pos = 8'h00;
      if (e == 4) frame_tick = 1'b1;
      if (e == 5) begin
        check("t5_overrun_pulse", 32'(tick_overrun), 32'd1);
        frame_tick = 1'b0;
      end
      if (e == 6) check("t5_overrun_clear", 32'(tick_overrun), 32'd0);
    end
    check("t5_done_count", 32'(done_cnt), 32'd1);
    check("t5_done_edge", 32'(done_edge), 32'd15);
    check("t5_overrun_count", 32'(ovr_cnt), 32'd1);
    check("t5_player_hit", 32'(player_hit), 32'd1);
`ifdef COLLISION_HIT_INDEX_EN
    check("t5_hit_index", 32'(hit_index), 32'd3);
`endif
    $display("scan t5 done_edge=%0d done_count=%0d overruns=%0d", done_edge, done_cnt, ovr_cnt);

    // 6: reset at edge 6 aborts the scan
    player_pos = 8'h34;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_player_hit", 32'(player_hit), 32'd0);
    check("t6_mask", 32'(sword_hit_mask), 32'h00);
    check("t6_done", 32'(done), 32'd0);
`ifdef COLLISION_HIT_INDEX_EN
    check("t6_hit_index", 32'(hit_index), 32'hF);
`endif
    done_cnt = 0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("t6_no_done", 32'(done_cnt), 32'd0);
    $display("scan t6 aborted, done pulses after abort=%0d", done_cnt);
    run_scan("t6b");
    check("t6b_player_hit", 32'(player_hit), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
